// File: rtl/sift_cmd_sequencer_if.sv
// Host-side command/response channel of the sift command sequencer.
// The host drives requests and response acceptance; the sequencer drives
// acceptance, the response payload and its busy indication.
interface sift_cmd_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic              req_type_i;
  logic [3:0]        req_cmd_i;
  logic              req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_timeout_o;
  logic              busy_o;

  // Host / bridge side
  modport master (
    output req_valid_i, req_op_i, req_type_i, req_cmd_i, req_addr_i, req_data_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o
  );

  // Sequencer side
  modport slave (
    input  req_valid_i, req_op_i, req_type_i, req_cmd_i, req_addr_i, req_data_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o
  );
endinterface

// File: rtl/sift_cmd_sequencer.sv
// sift_cmd_sequencer: runs one host command at a time against the
// sift_sector_core register port. Supports single writes, single reads,
// poll-until-mask-hit reads with a bounded retry count, and nops. Every
// command produces exactly one response.
module sift_cmd_sequencer #(
  parameter int DATA_W     = 32,
  parameter int POLL_GAP   = 4,
  parameter int POLL_MAX   = 1023,
  parameter int POLL_CNT_W = 10
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  sift_cmd_sequencer_if.slave host,
  output logic                core_type_o,
  output logic [3:0]          core_cmd_o,
  output logic                core_chipselect_o,
  output logic                core_write_o,
  output logic                core_read_o,
  output logic                core_address_o,
  output logic [DATA_W-1:0]   core_writedata_o,
  input  logic [DATA_W-1:0]   core_readdata_i
);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  // Gap counter runs 0 .. POLL_GAP-1 inside GAP
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_CNT_W-1:0] POLL_LAST = POLL_CNT_W'(POLL_MAX);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic                  armed_q;
  logic                  poll_q;
  logic [POLL_CNT_W-1:0] poll_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  rsp_timeout_q;
  logic                  type_q;
  logic [3:0]            cmd_q;
  logic                  addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  accept;
  logic                  cap_hit;
  logic                  cap_last;
  logic                  cap_done;
  logic                  cap_timeout;

  // A poll condition is met when any masked bit of the read word is set;
  // a zero mask therefore can never be met.
  function automatic logic poll_hit(input logic [DATA_W-1:0] rdata,
                                    input logic [DATA_W-1:0] mask);
    return |(rdata & mask);
  endfunction

  // Next state after the command/op decode; nop goes straight to RESP
  function automatic logic [2:0] accept_state(input logic [1:0] op);
    logic [2:0] s;
    case (op)
      OP_WR:   s = S_WR;
      OP_RD:   s = S_RD;
      OP_POLL: s = S_RD;
      default: s = S_RESP;
    endcase
    return s;
  endfunction

  // Ready needs a clock edge after reset release before it can rise, so
  // every output reads 0 until the first edge out of reset.
  assign host.req_ready_o = (state_q == S_IDLE) && armed_q;
  assign accept           = host.req_valid_i && host.req_ready_o;

  // In CAP the mask held on the write-data lines decides the poll outcome
  assign cap_hit     = poll_hit(core_readdata_i, wdata_q);
  assign cap_last    = (poll_cnt_q == POLL_LAST);
  assign cap_done    = !poll_q || cap_hit || cap_last;
  assign cap_timeout = poll_q && !cap_hit && cap_last;

  // Next-state decode of the command sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = accept_state(host.req_op_i);
        end
      end
      S_WR:   state_d = S_RESP;
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = cap_done ? S_RESP : S_GAP;
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_RD;
        end
      end
      S_RESP: begin
        if (host.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arms the request channel one edge after reset release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Held selection lines: captured only on accept and kept afterwards so the
  // core sees stable type/cmd/address between transactions
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      type_q  <= 1'b0;
      cmd_q   <= 4'd0;
      addr_q  <= 1'b0;
      wdata_q <= '0;
      poll_q  <= 1'b0;
    end else if (accept) begin
      type_q  <= host.req_type_i;
      cmd_q   <= host.req_cmd_i;
      addr_q  <= host.req_addr_i;
      wdata_q <= host.req_data_i;
      poll_q  <= (host.req_op_i == OP_POLL);
    end
  end

  // Number of read strobes issued for the current command
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      poll_cnt_q <= '0;
    end else if (accept) begin
      poll_cnt_q <= '0;
    end else if (state_q == S_RD) begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end

  // Idle-cycle counter between consecutive poll reads
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gap_cnt_q <= '0;
    end else if (state_q == S_CAP) begin
      gap_cnt_q <= '0;
    end else if (state_q == S_GAP && gap_cnt_q != GAP_LAST) begin
      gap_cnt_q <= gap_cnt_q + 1'b1;
    end
  end

  // Response payload: cleared on accept (write/nop answer 0), loaded in CAP
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (accept) begin
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (state_q == S_CAP) begin
      rsp_data_q    <= core_readdata_i;
      rsp_timeout_q <= cap_timeout;
    end
  end

  // Strobes and status decode straight from the registered state
  assign core_write_o      = (state_q == S_WR);
  assign core_read_o       = (state_q == S_RD);
  assign core_chipselect_o = core_write_o || core_read_o;
  assign core_type_o       = type_q;
  assign core_cmd_o        = cmd_q;
  assign core_address_o    = addr_q;
  assign core_writedata_o  = wdata_q;

  assign host.rsp_valid_o   = (state_q == S_RESP);
  assign host.rsp_data_o    = rsp_data_q;
  assign host.rsp_timeout_o = rsp_timeout_q;
  assign host.busy_o        = (state_q != S_IDLE);

  // Bus protocol properties of the strobe outputs
  a_strobe_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(core_write_o && core_read_o));
  a_cs_with_strobe: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    core_chipselect_o == (core_write_o || core_read_o));
  a_strobe_single: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (core_write_o || core_read_o) |=> !(core_write_o || core_read_o));

endmodule

// File: tb/tb_sift_cmd_sequencer.sv
// Self-checking bench for sift_cmd_sequencer: directed command vectors,
// a transaction-level expectation model checked every cycle, and literal
// per-command expectations.
module tb_sift_cmd_sequencer;
  localparam int DATA_W     = 32;
  localparam int POLL_GAP   = 4;
  localparam int POLL_MAX   = 5;
  localparam int POLL_CNT_W = 3;

  logic              clk_i;
  logic              reset_n_i;
  logic              core_type_o;
  logic [3:0]        core_cmd_o;
  logic              core_chipselect_o;
  logic              core_write_o;
  logic              core_read_o;
  logic              core_address_o;
  logic [DATA_W-1:0] core_writedata_o;
  logic [DATA_W-1:0] core_readdata_i;

  sift_cmd_sequencer_if #(.DATA_W(DATA_W)) host_if ();

  sift_cmd_sequencer #(
    .DATA_W(DATA_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX), .POLL_CNT_W(POLL_CNT_W)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .host(host_if),
    .core_type_o(core_type_o),
    .core_cmd_o(core_cmd_o),
    .core_chipselect_o(core_chipselect_o),
    .core_write_o(core_write_o),
    .core_read_o(core_read_o),
    .core_address_o(core_address_o),
    .core_writedata_o(core_writedata_o),
    .core_readdata_i(core_readdata_i)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Core register model: value returned by the k-th read of a command
  logic [DATA_W-1:0] rd_table [16];
  int core_reads = 0;

  // Observed strobe cycles and response-valid count
  int wr_q[$];
  int rd_q[$];
  int rv_cnt = 0;

  // Driver bookkeeping
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int lat     = 0;
  logic [DATA_W-1:0] got_data;
  logic              got_to;

  // Expectation model state
  bit                m_active = 0;
  bit                m_armed  = 0;
  int                m_off    = 0;
  int                m_wr_off = -1;
  int                m_rsp_off = 0;
  int                m_nrd    = 0;
  int                m_rd_off [16];
  logic [DATA_W-1:0] m_data   = '0;
  logic              m_to     = 1'b0;
  logic              m_type   = 1'b0;
  logic [3:0]        m_cmd    = 4'd0;
  logic              m_addr   = 1'b0;
  logic [DATA_W-1:0] m_wdata  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Core register port: each read strobe advances the read index and the
  // addressed word appears on readdata for the capture cycle
  initial begin
    core_readdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (core_read_o) begin
        core_reads++;
        core_readdata_i = rd_table[core_reads % 16];
      end
    end
  end

  // Compare process: checks every output each cycle against the model, then
  // advances the model using the inputs that the next edge will sample
  initial begin
    logic e_rdy, e_wr, e_rd, e_rv;
    int   n;
    bit   hit;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        chk("reset_ctrl_zero",
            {host_if.req_ready_o, host_if.busy_o, core_chipselect_o, core_write_o, core_read_o,
             host_if.rsp_valid_o, host_if.rsp_timeout_o, core_type_o, core_cmd_o, core_address_o},
            64'd0);
        chk("reset_data_zero", {host_if.rsp_data_o, core_writedata_o}, 64'd0);
        m_active = 0; m_armed = 0;
        m_type = 1'b0; m_cmd = 4'd0; m_addr = 1'b0; m_wdata = '0;
      end else begin
        e_rdy = !m_active && m_armed;
        e_wr  = m_active && (m_off == m_wr_off);
        e_rd  = 1'b0;
        for (int k = 0; k < m_nrd; k++)
          if (m_active && m_rd_off[k] == m_off) e_rd = 1'b1;
        e_rv  = m_active && (m_off >= m_rsp_off);

        chk("req_ready", {63'd0, host_if.req_ready_o}, {63'd0, e_rdy});
        chk("busy", {63'd0, host_if.busy_o}, {63'd0, m_active});
        chk("strobes", {61'd0, core_chipselect_o, core_write_o, core_read_o},
            {61'd0, e_wr | e_rd, e_wr, e_rd});
        chk("rsp_valid", {63'd0, host_if.rsp_valid_o}, {63'd0, e_rv});
        if (e_rv)
          chk("rsp_payload", {host_if.rsp_timeout_o, host_if.rsp_data_o}, {m_to, m_data});
        chk("held_lines", {core_type_o, core_cmd_o, core_address_o, core_writedata_o},
            {m_type, m_cmd, m_addr, m_wdata});

        if (core_write_o) wr_q.push_back(cyc);
        if (core_read_o) rd_q.push_back(cyc);
        if (host_if.rsp_valid_o) rv_cnt++;

        if (m_active) begin
          if (e_rv && host_if.rsp_ready_i) m_active = 0;
          else m_off++;
        end else if (e_rdy && host_if.req_valid_i) begin
          m_active = 1; m_off = 1;
          m_wr_off = -1; m_nrd = 0; m_data = '0; m_to = 1'b0;
          m_type = host_if.req_type_i; m_cmd = host_if.req_cmd_i;
          m_addr = host_if.req_addr_i; m_wdata = host_if.req_data_i;
          case (host_if.req_op_i)
            2'b00: begin m_wr_off = 1; m_rsp_off = 2; end
            2'b01: begin
              m_nrd = 1; m_rd_off[0] = 1; m_rsp_off = 3; m_data = rd_table[1];
            end
            2'b10: begin
              n = 0; hit = 0;
              for (int k = 1; k <= POLL_MAX && !hit; k++) begin
                n = k;
                if ((rd_table[k] & host_if.req_data_i) != 0) hit = 1;
              end
              m_nrd = n;
              for (int k = 0; k < n; k++) m_rd_off[k] = 1 + k * (POLL_GAP + 2);
              m_rsp_off = m_rd_off[n-1] + 2;
              m_data = rd_table[n];
              m_to = !hit;
            end
            default: m_rsp_off = 1;
          endcase
        end
        m_armed = 1;
      end
    end
  end

  task automatic start_cmd(input logic [1:0] op, input logic typ, input logic [3:0] cmd,
                           input logic addr, input logic [DATA_W-1:0] data);
    bit acc;
    acc = 0;
    @(posedge clk_i); #1;
    wr_q.delete(); rd_q.delete();
    core_reads = 0;
    host_if.req_op_i = op; host_if.req_type_i = typ; host_if.req_cmd_i = cmd;
    host_if.req_addr_i = addr; host_if.req_data_i = data; host_if.req_valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk_i);
      if (host_if.req_ready_o) begin
        @(posedge clk_i); #1;
        acc_cyc = cyc;
        host_if.req_valid_i = 1'b0;
        acc = 1;
      end
    end
    if (!acc) begin
      host_if.req_valid_i = 1'b0;
      flag_fail("accept_wait");
    end
  endtask

  task automatic finish_cmd(input int delay, input bit poke);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (host_if.rsp_valid_o) seen = 1;
    end
    if (!seen) begin
      flag_fail("rsp_wait");
      return;
    end
    rsp_cyc  = cyc;
    lat      = rsp_cyc - acc_cyc + 1;
    got_data = host_if.rsp_data_o;
    got_to   = host_if.rsp_timeout_o;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk_i); #1;
      host_if.req_valid_i = poke;
      host_if.req_op_i    = 2'b00;
      host_if.req_cmd_i   = 4'hF;
      @(negedge clk_i);
      chk("bp_hold", {62'd0, host_if.rsp_valid_o, host_if.req_ready_o}, 64'd2);
    end
    @(posedge clk_i); #1;
    host_if.req_valid_i = 1'b0;
    host_if.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    host_if.rsp_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_rd;
    reset_n_i = 1'b1;
    host_if.req_valid_i = 1'b0; host_if.req_op_i = 2'b00; host_if.req_type_i = 1'b0;
    host_if.req_cmd_i = 4'd0; host_if.req_addr_i = 1'b0; host_if.req_data_i = '0;
    host_if.rsp_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) rd_table[k] = '0;
    #1 reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;

    // Single write
    start_cmd(2'b00, 1'b1, 4'h3, 1'b0, 32'hA5A5_0001);
    finish_cmd(0, 0);
    chk("wr_latency", lat, 2);
    chk("wr_rsp_data", got_data, 0);
    chk("wr_strobe_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("wr_strobe_offset", wr_q[0] - acc_cyc + 1, 1);
    repeat (2) @(negedge clk_i);
    chk("cmd_still_held", core_cmd_o, 4'h3);

    // Single read
    rd_table[1] = 32'h0000_00C4;
    start_cmd(2'b01, 1'b0, 4'h5, 1'b1, 32'h0);
    finish_cmd(0, 0);
    chk("rd_latency", lat, 3);
    chk("rd_rsp_data", got_data, 32'hC4);
    chk("rd_timeout", got_to, 0);
    chk("rd_strobe_count", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("rd_strobe_offset", rd_q[0] - acc_cyc + 1, 1);

    // Poll succeeding on the 4th read
    for (int k = 0; k < 16; k++) rd_table[k] = '0;
    rd_table[4] = 32'h0000_0101;
    start_cmd(2'b10, 1'b0, 4'h9, 1'b1, 32'h1);
    finish_cmd(0, 0);
    chk("poll_read_count", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      chk("poll_spacing_a", rd_q[1] - rd_q[0], 6);
      chk("poll_spacing_b", rd_q[3] - rd_q[2], 6);
    end
    chk("poll_rsp_data", got_data, 32'h101);
    chk("poll_timeout", got_to, 0);

    // Poll timing out after POLL_MAX reads
    for (int k = 0; k < 16; k++) rd_table[k] = '0;
    start_cmd(2'b10, 1'b1, 4'hA, 1'b0, 32'h1);
    finish_cmd(0, 0);
    chk("pto_read_count", rd_q.size(), 5);
    chk("pto_timeout", got_to, 1);
    chk("pto_rsp_data", got_data, 0);

    // Zero mask: never satisfied even with all bits set in the register
    for (int k = 0; k < 16; k++) rd_table[k] = 32'hFFFF_FFFF;
    start_cmd(2'b10, 1'b0, 4'h2, 1'b1, 32'h0);
    finish_cmd(0, 0);
    chk("mask0_read_count", rd_q.size(), 5);
    chk("mask0_timeout", got_to, 1);
    chk("mask0_rsp_data", got_data, 32'hFFFF_FFFF);

    // Nop with a 10-cycle response stall and a new request raised meanwhile
    start_cmd(2'b11, 1'b1, 4'h3, 1'b0, 32'h1234);
    finish_cmd(10, 1);
    chk("nop_latency", lat, 1);
    chk("nop_rsp_data", got_data, 0);
    chk("nop_strobes", wr_q.size() + rd_q.size(), 0);

    // Reset asserted while a poll sits in its gap
    for (int k = 0; k < 16; k++) rd_table[k] = '0;
    start_cmd(2'b10, 1'b0, 4'h6, 1'b1, 32'h1);
    seen_rd = 0;
    for (int i = 0; i < 20 && !seen_rd; i++) begin
      @(negedge clk_i);
      if (core_read_o) seen_rd = 1;
    end
    if (!seen_rd) flag_fail("reset_poll_read_wait");
    @(posedge clk_i);
    @(posedge clk_i);
    #3 reset_n_i = 1'b0;
    #1;
    chk("reset_immediate", {host_if.busy_o, core_cmd_o, core_writedata_o}, 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    rv_cnt = 0;
    repeat (40) @(negedge clk_i);
    chk("no_rsp_after_reset", rv_cnt, 0);

    // Normal read after the reset
    rd_table[1] = 32'hDEAD_BEEF;
    start_cmd(2'b01, 1'b1, 4'h7, 1'b0, 32'h0);
    finish_cmd(0, 0);
    chk("post_reset_rd_data", got_data, 32'hDEAD_BEEF);
    chk("post_reset_rd_latency", lat, 3);

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
